// File: rtl/fifo_status.sv
// Synchronous FIFO with occupancy count, level flags and sticky overflow/underflow.
// Define FIFO_STATUS_FWFT_EN for first-word fall-through output; default is a registered read port.
module fifo_status #(
    parameter int DEPTH    = 16,
    parameter int WIDTH    = 8,
    parameter int AF_LEVEL = DEPTH - 2,
    parameter int AE_LEVEL = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clr,
    input  logic [WIDTH-1:0]           in,
    input  logic                       wr_en,
    input  logic                       rd_en,
    output logic [WIDTH-1:0]           out,
    output logic                       empty,
    output logic                       full,
    output logic                       almost_empty,
    output logic                       almost_full,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       overflow,
    output logic                       underflow
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             wr_acc;
    logic             rd_acc;

    // Pointers wrap explicitly so DEPTH need not be a power of two.
    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign empty        = (count == '0);
    assign full         = (count == CW'(DEPTH));
    assign almost_empty = (count <= CW'(AE_LEVEL));
    assign almost_full  = (count >= CW'(AF_LEVEL));

    assign wr_acc = wr_en & ~full & ~clr;
    assign rd_acc = rd_en & ~empty & ~clr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (clr) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_acc) wr_ptr <= ptr_next(wr_ptr);
            if (rd_acc) rd_ptr <= ptr_next(rd_ptr);
            if (wr_acc && !rd_acc)      count <= count + CW'(1);
            else if (rd_acc && !wr_acc) count <= count - CW'(1);
            if (wr_en && full)  overflow  <= 1'b1;
            if (rd_en && empty) underflow <= 1'b1;
        end
    end

    // Storage is intentionally left uncleared by reset and flush.
    always_ff @(posedge clk) begin
        if (wr_acc) mem[wr_ptr] <= in;
    end

`ifdef FIFO_STATUS_FWFT_EN
    assign out = empty ? '0 : mem[rd_ptr];
`else
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out <= '0;
        end else if (clr) begin
            out <= '0;
        end else if (rd_acc) begin
            out <= mem[rd_ptr];
        end
    end
`endif

endmodule

// File: tb/tb_fifo_status.sv
// Randomized and directed self-checking bench for fifo_status (DEPTH=5, AF=4, AE=1),
// compared each cycle against a queue-based reference model.
module tb_fifo_status;

    localparam int DEPTH = 5;
    localparam int WIDTH = 8;
    localparam int AF    = 4;
    localparam int AE    = 1;
    localparam int CW    = $clog2(DEPTH + 1);

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             clr = 1'b0;
    logic [WIDTH-1:0] in = '0;
    logic             wr_en = 1'b0;
    logic             rd_en = 1'b0;
    logic [WIDTH-1:0] out;
    logic             empty, full, almost_empty, almost_full;
    logic [CW-1:0]    count;
    logic             overflow, underflow;

    int checks = 0;
    int failures = 0;

    // Reference model state
    logic [7:0] q[$];
    logic [7:0] m_out = '0;
    bit         m_ovf = 0;
    bit         m_udf = 0;

    fifo_status #(.DEPTH(DEPTH), .WIDTH(WIDTH), .AF_LEVEL(AF), .AE_LEVEL(AE)) dut (
        .clk(clk), .rst_n(rst_n), .clr(clr), .in(in), .wr_en(wr_en), .rd_en(rd_en),
        .out(out), .empty(empty), .full(full), .almost_empty(almost_empty),
        .almost_full(almost_full), .count(count), .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all();
        int n;
        int exp_out;
        n = q.size();
`ifdef FIFO_STATUS_FWFT_EN
        exp_out = (n == 0) ? 0 : int'(q[0]);
`else
        exp_out = int'(m_out);
`endif
        chk("count", int'(count), n);
        chk("empty", int'(empty), int'(n == 0));
        chk("full", int'(full), int'(n == DEPTH));
        chk("almost_empty", int'(almost_empty), int'(n <= AE));
        chk("almost_full", int'(almost_full), int'(n >= AF));
        chk("overflow", int'(overflow), int'(m_ovf));
        chk("underflow", int'(underflow), int'(m_udf));
        chk("out", int'(out), exp_out);
    endtask

    task automatic model_reset();
        q.delete();
        m_out = '0;
        m_ovf = 0;
        m_udf = 0;
    endtask

    // Drive one cycle of inputs, advance the model at the edge, check just after it.
    task automatic cycle(input bit w, input bit r, input bit c, input logic [7:0] d);
        bit was_full, was_empty;
        wr_en = w; rd_en = r; clr = c; in = d;
        @(posedge clk);
        was_full  = (q.size() == DEPTH);
        was_empty = (q.size() == 0);
        if (c) begin
            model_reset();
        end else begin
            if (w && was_full)  m_ovf = 1;
            if (r && was_empty) m_udf = 1;
            if (r && !was_empty) m_out = q.pop_front();
            if (w && !was_full)  q.push_back(d);
        end
        #1;
        check_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, 0, 8'h00);
    endtask

    initial begin
        logic [7:0] fill_data [5];
        fill_data[0] = 8'h11; fill_data[1] = 8'h22; fill_data[2] = 8'h33;
        fill_data[3] = 8'h44; fill_data[4] = 8'h55;

        #3;
        model_reset();
        check_all();
        @(negedge clk);
        rst_n = 1'b1;

        // Fill to full, then overflow attempt
        for (int i = 0; i < 5; i++) cycle(1, 0, 0, fill_data[i]);
        cycle(1, 0, 0, 8'h66);

        // Drain across the pointer wrap, then underflow
        cycle(0, 1, 0, 8'h00);
        cycle(0, 1, 0, 8'h00);
        cycle(1, 0, 0, 8'hA1);
        cycle(1, 0, 0, 8'hA2);
        for (int i = 0; i < 5; i++) cycle(0, 1, 0, 8'h00);
        chk("drain_last", int'(m_out), 8'hA2);
        cycle(0, 1, 0, 8'h00);

        // Simultaneous read/write at mid, full and empty levels
        cycle(0, 0, 1, 8'h00);
        for (int i = 0; i < 3; i++) cycle(1, 0, 0, 8'h30 + 8'(i));
        for (int i = 0; i < 4; i++) cycle(1, 1, 0, 8'h40 + 8'(i));
        cycle(1, 0, 0, 8'h50);
        cycle(1, 0, 0, 8'h51);
        cycle(1, 1, 0, 8'h52);
        cycle(0, 0, 1, 8'h00);
        cycle(1, 1, 0, 8'h60);

        // Flush with overflow set and a concurrent write
        for (int i = 0; i < 4; i++) cycle(1, 0, 0, 8'h70 + 8'(i));
        cycle(1, 0, 0, 8'h7E);
        cycle(0, 1, 0, 8'h00);
        cycle(0, 1, 0, 8'h00);
        cycle(1, 0, 1, 8'hEE);

        // Asynchronous reset between edges at count 4
        for (int i = 0; i < 4; i++) cycle(1, 0, 0, 8'h80 + 8'(i));
        wr_en = 0; rd_en = 0;
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        #2 rst_n = 1'b1;
        for (int i = 0; i < 3; i++) cycle(1, 0, 0, 8'h90 + 8'(i));
        for (int i = 0; i < 3; i++) cycle(0, 1, 0, 8'h00);

        // Output timing of a single write into an empty FIFO
        cycle(1, 0, 0, 8'h5A);
        idle(2);
        cycle(0, 1, 0, 8'h00);
        idle(1);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            cycle(($urandom_range(99) < 55), ($urandom_range(99) < 50),
                  ($urandom_range(99) < 3), 8'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
